// File: rtl/apb_completer_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package  : apb_completer_regfile_pkg
// Brief    : Shared APB types and widths for the completer register file,
//            its requester and their benches.
// Revision : 1.0  initial release
// ============================================================================
package apb_completer_regfile_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned APB_WAIT_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

endpackage : apb_completer_regfile_pkg
`default_nettype wire

// File: rtl/apb_completer_regfile_if.sv
`default_nettype none
// ============================================================================
// Interface : apb_completer_regfile_if
// Brief     : APB bus bundle between one requester slave-select and one
//             completer; master = requester side, slave = completer side.
// Revision  : 1.0  initial release
// ============================================================================
interface apb_completer_regfile_if
  import apb_completer_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface : apb_completer_regfile_if
`default_nettype wire

// File: rtl/apb_completer_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_completer_regfile_mem
// Brief    : MEM_DEPTH x DATA_W storage array. Synchronous write port,
//            combinational read port, whole array cleared on preset.
// Revision : 1.0  initial release
// ============================================================================
module apb_completer_regfile_mem
  import apb_completer_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W    = APB_ADDR_W,
  parameter int unsigned DATA_W    = APB_DATA_W,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  // Storage: cleared asynchronously; the caller only raises we_i for in-range addresses
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: out-of-range addresses read as zero so no unimplemented row is ever touched
  always_comb begin
    rdata_o = '0;
    if ({{(32-ADDR_W){1'b0}}, raddr_i} < MEM_DEPTH) begin
      rdata_o = mem_q[raddr_i];
    end
  end

endmodule : apb_completer_regfile_mem
`default_nettype wire

// File: rtl/apb_completer_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_completer_regfile
// Brief    : APB completer fronting a byte-wide register file. Inserts
//            WAIT_STATES stall cycles, flags out-of-range addresses with
//            PSLVERR and abandons transfers cleanly on protocol violations.
// Revision : 1.0  initial release
// ============================================================================
module apb_completer_regfile
  import apb_completer_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   pclk,
  input  logic                   preset,
  apb_completer_regfile_if.slave bus
);

  // The stall counter is APB_WAIT_W bits wide; larger settings cannot be represented
  if (WAIT_STATES > ((1 << APB_WAIT_W) - 1)) begin : g_bad_wait_states
    $error("apb_completer_regfile: WAIT_STATES exceeds the stall counter range");
  end

  localparam logic [APB_WAIT_W-1:0] c_wait_load = WAIT_STATES[APB_WAIT_W-1:0];
  localparam logic [APB_WAIT_W-1:0] c_one       = {{(APB_WAIT_W-1){1'b0}}, 1'b1};

  apb_state_t            state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic                  err_q;
  logic [APB_WAIT_W-1:0] cnt_q;
  logic [DATA_W-1:0]     prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic                  setup;
  logic                  addr_err;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  // A setup phase is recognised in either state; in ACCESS it acts as a restart
  assign setup    = bus.psel & ~bus.penable;
  assign addr_err = ({{(32-ADDR_W){1'b0}}, bus.paddr} >= MEM_DEPTH);

  // Commit only on the completing edge of a good write, to the address latched at setup
  assign mem_we = (state_q == ACCESS) & bus.psel & bus.penable & pready_q
                & write_q & ~err_q;

  // Transfer FSM: pready_q is kept equal to (cnt_q == 0) while in ACCESS
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else if (setup) begin
      state_q   <= ACCESS;
      addr_q    <= bus.paddr;
      write_q   <= bus.pwrite;
      err_q     <= addr_err;
      cnt_q     <= c_wait_load;
      pready_q  <= (c_wait_load == '0);
      pslverr_q <= (c_wait_load == '0) & addr_err;
      if (!bus.pwrite) begin
        prdata_q <= addr_err ? '0 : mem_rdata;
      end
    end else if (state_q == ACCESS) begin
      if (!bus.psel || pready_q) begin
        // Completion or abort: either way the bus returns to idle
        state_q   <= IDLE;
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_q - c_one;
        pready_q  <= (cnt_q == c_one);
        pslverr_q <= (cnt_q == c_one) & err_q;
      end
    end
  end

  apb_completer_regfile_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .pclk    (pclk),
    .preset  (preset),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (bus.pwdata),
    .raddr_i (bus.paddr),
    .rdata_o (mem_rdata)
  );

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;

endmodule : apb_completer_regfile
`default_nettype wire
